// File: rtl/alu_srcb_pkg.sv
// ---------------------------------------------------------------------------
// alu_srcb_pkg
// Shared constants for the ALU operand-B source stage. It holds the
// source-select encodings and the select width.
// Optional feature macro used by the importing files: ALU_SRCB_SELCHK_EN.
// ---------------------------------------------------------------------------
package alu_srcb_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SRCB_RT       = 3'd0;
    localparam logic [SEL_W-1:0] SRCB_CONST    = 3'd1;
    localparam logic [SEL_W-1:0] SRCB_SEXT     = 3'd2;
    localparam logic [SEL_W-1:0] SRCB_SEXT_SL2 = 3'd3;
    localparam logic [SEL_W-1:0] SRCB_SHIFT    = 3'd4;
    localparam logic [SEL_W-1:0] SRCB_ZEXT     = 3'd5;

endpackage : alu_srcb_pkg

// File: rtl/srcb_select.sv
// ---------------------------------------------------------------------------
// srcb_select
// Purely combinational operand-B source mux and immediate extension unit.
// Ports:
//   sel        in   SEL_W   source select (encodings in alu_srcb_pkg)
//   rt         in   DATA_W  register-file rt value
//   imm        in   IMM_W   instruction immediate
//   shift_val  in   DATA_W  shift-register value
//   data       out  DATA_W  selected/extended operand
//   rsvd       out  1       sel is a reserved encoding (only present when
//                           ALU_SRCB_SELCHK_EN is defined)
// ---------------------------------------------------------------------------
module srcb_select
    import alu_srcb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_INC = 4
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] rt,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] shift_val,
`ifdef ALU_SRCB_SELCHK_EN
    output logic              rsvd,
`endif
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};

    always_comb begin
        data = '0;
        case (sel)
            SRCB_RT:       data = rt;
            SRCB_CONST:    data = DATA_W'(CONST_INC);
            SRCB_SEXT:     data = imm_sext;
            // shifted-out top bits are dropped; result stays DATA_W wide
            SRCB_SEXT_SL2: data = {imm_sext[DATA_W-3:0], 2'b00};
            SRCB_SHIFT:    data = shift_val;
            SRCB_ZEXT:     data = imm_zext;
            default:       data = '0;
        endcase
    end

`ifdef ALU_SRCB_SELCHK_EN
    assign rsvd = (sel > SRCB_ZEXT);
`endif

endmodule : srcb_select

// File: rtl/alu_srcb_stage.sv
// ---------------------------------------------------------------------------
// alu_srcb_stage
// Registered ALU operand-B source stage. The selected operand is computed at
// push time and held in a 2-entry elastic buffer with valid/ready on both
// sides. The buffer's head slot drives out_data directly. in_ready is a
// register, so there is no combinational path from out_ready to in_ready.
// Optional feature: define ALU_SRCB_SELCHK_EN to store a reserved-select error
// bit with each entry and report it on sel_err while that entry is at head.
// Ports:
//   clk        in   1       clock, rising edge
//   reset_n    in   1       asynchronous active-low reset
//   flush      in   1       synchronous clear of all entries (beats push/pop)
//   in_valid   in   1       upstream presents sel/operands
//   in_ready   out  1       stage can accept (registered)
//   sel        in   3       source select
//   rt         in   DATA_W  register-file rt value
//   imm        in   IMM_W   instruction immediate
//   shift_val  in   DATA_W  shift-register value
//   out_valid  out  1       out_data valid
//   out_ready  in   1       ALU consumes out_data
//   out_data   out  DATA_W  head entry
//   sel_err    out  1       head entry had a reserved select (0 without macro)
// ---------------------------------------------------------------------------
module alu_srcb_stage
    import alu_srcb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_INC = 4,
    parameter int DEPTH     = 2   // only 2 is supported; the buffer is head/tail
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] rt,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] shift_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              sel_err
);

`ifdef ALU_SRCB_SELCHK_EN
    localparam int ENT_W = DATA_W + 1;   // {err, data}
`else
    localparam int ENT_W = DATA_W;
`endif

    logic [DATA_W-1:0] sel_data;
    logic [ENT_W-1:0]  new_ent;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  tail;
    logic [1:0]        count;
    logic              push;
    logic              pop;

`ifdef ALU_SRCB_SELCHK_EN
    logic sel_rsvd;

    srcb_select #(
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .CONST_INC (CONST_INC)
    ) u_select (
        .sel       (sel),
        .rt        (rt),
        .imm       (imm),
        .shift_val (shift_val),
        .rsvd      (sel_rsvd),
        .data      (sel_data)
    );

    assign new_ent = {sel_rsvd, sel_data};
    assign sel_err = out_valid && head[DATA_W];
`else
    srcb_select #(
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .CONST_INC (CONST_INC)
    ) u_select (
        .sel       (sel),
        .rt        (rt),
        .imm       (imm),
        .shift_val (shift_val),
        .data      (sel_data)
    );

    assign new_ent = sel_data;
    assign sel_err = 1'b0;
`endif

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = head[DATA_W-1:0];

    // in_ready is updated alongside count so it always equals (count < 2).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= 2'd0;
            in_ready <= 1'b1;
            head     <= '0;
            tail     <= '0;
        end else if (flush) begin
            count    <= 2'd0;
            in_ready <= 1'b1;
            head     <= '0;
            tail     <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= new_ent;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= new_ent;
                    end else if (push) begin
                        tail     <= new_ent;
                        count    <= 2'd2;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // full: in_ready is low, so only a pop can happen
                    if (pop) begin
                        head     <= tail;
                        count    <= 2'd1;
                        in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule : alu_srcb_stage
